// File: rtl/mult_sched.sv
// Round-robin scheduler in front of the shared 3-stage complex/real multiplier.
// Tracks in-flight ops, inserts a bubble on mode changes and queues tagged results.
module mult_sched #(
    parameter int TAG_W      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [1:0]           req_mode,
    input  logic [63:0]          req_a_re,
    input  logic [63:0]          req_a_im,
    input  logic [63:0]          req_b_re,
    input  logic [63:0]          req_b_im,
    input  logic [2*TAG_W-1:0]   req_tag,
    output logic                 m_complex_real,
    output logic [31:0]          m_real_a,
    output logic [31:0]          m_real_b,
    output logic [31:0]          m_im_a,
    output logic [31:0]          m_im_b,
    input  logic [63:0]          m_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [63:0]          rsp_data,
    output logic                 rsp_src,
    output logic [TAG_W-1:0]     rsp_tag,
    output logic                 busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    logic                  rr_q;
    logic                  mode_q;
    logic                  last_issue_q;
    logic [2:0]            trk_v;
    logic [2:0]            trk_src;
    logic [2:0][TAG_W-1:0] trk_tag;

    logic [63:0]           f_data [FIFO_DEPTH];
    logic                  f_src  [FIFO_DEPTH];
    logic [TAG_W-1:0]      f_tag  [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    logic                  any_valid;
    logic                  sel;
    logic                  sel_mode;
    logic [TAG_W-1:0]      sel_tag;
    logic [1:0]            in_flight;
    logic [OCC_W-1:0]      occ;
    logic                  credit_ok;
    logic                  bubble;
    logic                  issue;
    logic                  push;
    logic                  pop;

    assign rsp_valid = (count != '0);
    assign rsp_data  = f_data[rd_ptr];
    assign rsp_src   = f_src[rd_ptr];
    assign rsp_tag   = f_tag[rd_ptr];
    assign busy      = (|trk_v) | rsp_valid;
    assign push      = trk_v[2];
    assign pop       = rsp_valid & rsp_ready;

    always_comb begin
        any_valid = |req_valid;
        sel       = (req_valid == 2'b11) ? rr_q : req_valid[1];
        sel_mode  = sel ? req_mode[1] : req_mode[0];
        sel_tag   = sel ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
        in_flight = {1'b0, trk_v[0]} + {1'b0, trk_v[1]} + {1'b0, trk_v[2]};
        // An entry popped this cycle frees its slot immediately, which keeps
        // full throughput with a 4-deep FIFO behind a 3-stage pipeline.
        occ       = OCC_W'(count) + OCC_W'(in_flight) - OCC_W'(pop);
        credit_ok = occ < OCC_W'(FIFO_DEPTH);
        bubble    = any_valid & last_issue_q & (sel_mode != mode_q);
        issue     = any_valid & ~bubble & credit_ok & ~reset;

        req_ready      = {issue & sel, issue & ~sel};
        m_complex_real = issue ? sel_mode : mode_q;
        m_real_a = '0;
        m_real_b = '0;
        m_im_a   = '0;
        m_im_b   = '0;
        if (issue) begin
            m_real_a = sel ? req_a_re[63:32] : req_a_re[31:0];
            m_real_b = sel ? req_b_re[63:32] : req_b_re[31:0];
            m_im_a   = sel ? req_a_im[63:32] : req_a_im[31:0];
            m_im_b   = sel ? req_b_im[63:32] : req_b_im[31:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_q         <= 1'b0;
            mode_q       <= 1'b0;
            last_issue_q <= 1'b0;
            trk_v        <= '0;
            trk_src      <= '0;
            trk_tag      <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                f_data[i] <= '0;
                f_src[i]  <= 1'b0;
                f_tag[i]  <= '0;
            end
        end else begin
            // The mode register changes during the bubble so the previous op
            // still sees its own mode in its second multiplier stage.
            if (issue || bubble) begin
                mode_q <= sel_mode;
            end
            if (issue) begin
                rr_q <= ~sel;
            end
            last_issue_q <= issue;
            trk_v        <= {trk_v[1:0], issue};
            trk_src      <= {trk_src[1:0], sel};
            trk_tag      <= {trk_tag[1:0], sel_tag};

            if (push) begin
                f_data[wr_ptr] <= m_out;
                f_src[wr_ptr]  <= trk_src[2];
                f_tag[wr_ptr]  <= trk_tag[2];
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_mult_sched.sv
// Bench for mult_sched: behavioural multiplier plus a queue-based reference of
// grants, operand routing, mode handling and tagged result delivery.
module tb_mult_sched;

    localparam int TAG_W = 4;
    localparam int DEPTH = 4;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0]          req_mode;
    logic [63:0]         req_a_re;
    logic [63:0]         req_a_im;
    logic [63:0]         req_b_re;
    logic [63:0]         req_b_im;
    logic [2*TAG_W-1:0]  req_tag;
    logic                m_complex_real;
    logic [31:0]         m_real_a;
    logic [31:0]         m_real_b;
    logic [31:0]         m_im_a;
    logic [31:0]         m_im_b;
    logic [63:0]         m_out;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [63:0]         rsp_data;
    logic                rsp_src;
    logic [TAG_W-1:0]    rsp_tag;
    logic                busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    mult_sched #(.TAG_W(TAG_W), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_a_re(req_a_re), .req_a_im(req_a_im), .req_b_re(req_b_re), .req_b_im(req_b_im),
        .req_tag(req_tag),
        .m_complex_real(m_complex_real), .m_real_a(m_real_a), .m_real_b(m_real_b),
        .m_im_a(m_im_a), .m_im_b(m_im_b), .m_out(m_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_src(rsp_src), .rsp_tag(rsp_tag), .busy(busy)
    );

    function automatic logic [31:0] hi(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        p = {32'b0, x} * {32'b0, y};
        return p[63:32];
    endfunction

    function automatic logic [63:0] calc(input logic cplx, input logic [31:0] ar, input logic [31:0] ai,
                                         input logic [31:0] br, input logic [31:0] bi);
        if (cplx) return {hi(ar, br) - hi(ai, bi), hi(ar, bi) + hi(ai, br)};
        return {hi(ar, br), hi(ai, bi)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Multiplier model: mode is sampled in stage 1 and stage 2; a mismatch
    // between the two samples yields a visibly corrupted product.
    logic [31:0] s1_ar, s1_ai, s1_br, s1_bi, s2_ar, s2_ai, s2_br, s2_bi;
    logic        s1_m, s2_m, s2_m2;
    always @(posedge clock) begin
        if (reset) begin
            s1_ar <= 0; s1_ai <= 0; s1_br <= 0; s1_bi <= 0; s1_m <= 0;
            s2_ar <= 0; s2_ai <= 0; s2_br <= 0; s2_bi <= 0; s2_m <= 0; s2_m2 <= 0;
            m_out <= 0;
        end else begin
            s1_ar <= m_real_a; s1_ai <= m_im_a; s1_br <= m_real_b; s1_bi <= m_im_b;
            s1_m  <= m_complex_real;
            s2_ar <= s1_ar; s2_ai <= s1_ai; s2_br <= s1_br; s2_bi <= s1_bi;
            s2_m  <= s1_m;
            s2_m2 <= m_complex_real;
            m_out <= calc(s2_m, s2_ar, s2_ai, s2_br, s2_bi)
                     ^ ((s2_m != s2_m2) ? 64'hDEAD_BEEF_DEAD_BEEF : 64'h0);
        end
    end

    // Reference model: outstanding results live in one queue from grant to pop.
    typedef struct packed {
        logic [63:0]      data;
        logic             src;
        logic [TAG_W-1:0] tag;
        logic [31:0]      rdy;
    } rsp_t;

    rsp_t        q[$];
    rsp_t        md_e;
    logic        md_rr = 0, md_last = 0, md_held = 0;
    logic        md_any, md_sel, md_mode, md_bub, md_grant, md_vld, md_pop;
    logic [31:0] md_ar, md_ai, md_br, md_bi;
    logic [TAG_W-1:0] md_tag;
    int          md_out;

    always @(negedge clock) begin
        if (reset) begin
            chk("ready_in_reset", 64'(req_ready), 64'd0);
            q.delete();
            md_rr = 0; md_last = 0; md_held = 0;
        end else begin
            md_vld  = (q.size() > 0) && (q[0].rdy <= 32'(cyc));
            md_pop  = md_vld && rsp_ready;
            md_any  = |req_valid;
            md_sel  = (req_valid == 2'b11) ? md_rr : req_valid[1];
            md_mode = req_mode[md_sel];
            md_ar   = md_sel ? req_a_re[63:32] : req_a_re[31:0];
            md_ai   = md_sel ? req_a_im[63:32] : req_a_im[31:0];
            md_br   = md_sel ? req_b_re[63:32] : req_b_re[31:0];
            md_bi   = md_sel ? req_b_im[63:32] : req_b_im[31:0];
            md_tag  = md_sel ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
            md_bub  = md_any && md_last && (md_mode != md_held);
            md_out  = q.size() - (md_pop ? 1 : 0);
            md_grant = md_any && !md_bub && (md_out < DEPTH);

            chk("req_ready", 64'(req_ready), md_grant ? (md_sel ? 64'd2 : 64'd1) : 64'd0);
            chk("m_mode", 64'(m_complex_real), 64'(md_grant ? md_mode : md_held));
            chk("m_ops_re", {m_real_a, m_real_b}, md_grant ? {md_ar, md_br} : 64'd0);
            chk("m_ops_im", {m_im_a, m_im_b}, md_grant ? {md_ai, md_bi} : 64'd0);
            chk("rsp_valid", 64'(rsp_valid), 64'(md_vld));
            if (md_vld) begin
                chk("rsp_data", rsp_data, q[0].data);
                chk("rsp_src_tag", 64'({rsp_src, rsp_tag}), 64'({q[0].src, q[0].tag}));
            end
            chk("busy", 64'(busy), 64'(q.size() > 0));

            if (md_pop) void'(q.pop_front());
            if (md_grant) begin
                md_e.data = calc(md_mode, md_ar, md_ai, md_br, md_bi);
                md_e.src  = md_sel;
                md_e.tag  = md_tag;
                md_e.rdy  = 32'(cyc + 4);
                q.push_back(md_e);
                md_rr = ~md_sel;
            end
            if (md_grant || md_bub) md_held = md_mode;
            md_last = md_grant;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int r, input logic mode, input logic [31:0] ar, input logic [31:0] ai,
                           input logic [31:0] br, input logic [31:0] bi, input logic [TAG_W-1:0] tag);
        req_mode[r]           = mode;
        req_a_re[r*32 +: 32]  = ar;
        req_a_im[r*32 +: 32]  = ai;
        req_b_re[r*32 +: 32]  = br;
        req_b_im[r*32 +: 32]  = bi;
        req_tag[r*TAG_W +: TAG_W] = tag;
    endtask

    task automatic wait_grant(input int r, output int t);
        t = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (req_ready[r]) begin
                t = cyc;
                return;
            end
        end
        total++; bad++;
        $display("FAIL grant_timeout: req%0d got no grant, required one within 30 cycles", r);
    endtask

    task automatic wait_rsp(output int t);
        t = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (rsp_valid) begin
                t = cyc;
                return;
            end
        end
        total++; bad++;
        $display("FAIL rsp_timeout: rsp_valid stayed 0, required 1 within 30 cycles");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    int t0, t1, t2, gcnt, rcnt;
    logic [1:0] gseq [10];

    initial begin
        req_valid = 0; req_mode = 0; req_a_re = 0; req_a_im = 0; req_b_re = 0; req_b_im = 0;
        req_tag = 0; rsp_ready = 1; reset = 1;
        repeat (3) tick();
        reset = 0;
        @(negedge clock);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mode", 64'(m_complex_real), 64'd0);
        chk("rst_ops", {m_real_a, m_real_b} | {m_im_a, m_im_b}, 64'd0);
        chk("rst_rsp", rsp_data, 64'd0);
        chk("rst_rsp_src_tag", 64'({rsp_src, rsp_tag}), 64'd0);

        // Single real op from requester 0.
        tick();
        set_req(0, 1'b0, 32'h8000_0000, 32'h0001_0000, 32'h4, 32'h0001_0000, 4'd5);
        req_valid = 2'b01;
        wait_grant(0, t0);
        tick();
        req_valid = 0;
        wait_rsp(t1);
        chk("real_latency", 64'(t1 - t0), 64'd4);
        chk("real_data", rsp_data, 64'h0000_0002_0000_0001);
        chk("real_src_tag", 64'({rsp_src, rsp_tag}), 64'h05);

        // Complex op from requester 1.
        tick();
        set_req(1, 1'b1, 32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 32'h4000_0000, 4'd9);
        req_valid = 2'b10;
        wait_grant(1, t0);
        tick();
        req_valid = 0;
        wait_rsp(t1);
        chk("cplx_latency", 64'(t1 - t0), 64'd4);
        chk("cplx_data", rsp_data, 64'h3000_0000_4000_0000);
        chk("cplx_src_tag", 64'({rsp_src, rsp_tag}), 64'h19);

        // Both requesters, same mode, consumer always ready.
        tick();
        set_req(0, 1'b0, 32'h1234_5678, 32'h9abc_def0, 32'h0fed_cba9, 32'h7654_3210, 4'd1);
        set_req(1, 1'b0, 32'hffff_ffff, 32'h8000_0001, 32'hffff_ffff, 32'h0000_0003, 4'd2);
        req_valid = 2'b11;
        gcnt = 0; rcnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            gseq[i] = req_ready;
            if (req_ready != 2'b00) gcnt++;
            if (i >= 4 && rsp_valid) rcnt++;
        end
        tick();
        req_valid = 0;
        chk("rr_grant_count", 64'(gcnt), 64'd10);
        for (int i = 0; i < 10; i++) chk("rr_order", 64'(gseq[i]), (i % 2 == 0) ? 64'd1 : 64'd2);
        chk("rr_result_rate", 64'(rcnt), 64'd6);
        repeat (8) tick();

        // Alternating modes from one requester: a bubble before each switch.
        set_req(0, 1'b0, 32'h8000_0000, 32'h0001_0000, 32'h4, 32'h0001_0000, 4'd3);
        req_valid = 2'b01;
        wait_grant(0, t0);
        tick();
        set_req(0, 1'b1, 32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 32'h4000_0000, 4'd4);
        wait_grant(0, t1);
        tick();
        set_req(0, 1'b0, 32'hdead_beef, 32'h0000_0001, 32'h0000_0002, 32'hcafe_f00d, 4'd6);
        wait_grant(0, t2);
        tick();
        req_valid = 0;
        chk("bubble_gap_1", 64'(t1 - t0), 64'd2);
        chk("bubble_gap_2", 64'(t2 - t1), 64'd2);
        repeat (8) tick();

        // Backpressure: credit limits outstanding ops to the FIFO depth.
        rsp_ready = 0;
        set_req(0, 1'b0, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 32'h0000_0040, 4'd7);
        set_req(1, 1'b0, 32'h0100_0000, 32'h0200_0000, 32'h0300_0000, 32'h0400_0000, 4'd8);
        req_valid = 2'b11;
        gcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (req_ready != 2'b00) gcnt++;
        end
        chk("bp_grants_full", 64'(gcnt), 64'd4);
        tick();
        rsp_ready = 1;
        gcnt = 0;
        @(negedge clock);
        if (req_ready != 2'b00) gcnt++;
        tick();
        rsp_ready = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            if (req_ready != 2'b00) gcnt++;
        end
        chk("bp_grants_after_pop", 64'(gcnt), 64'd1);
        tick();
        req_valid = 0;
        rsp_ready = 1;
        repeat (10) tick();

        // Reset with two ops in flight and one queued.
        rsp_ready = 0;
        set_req(0, 1'b0, 32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 32'h0000_4000, 4'd10);
        req_valid = 2'b01;
        wait_grant(0, t0);
        repeat (3) tick();
        req_valid = 0;
        tick();
        reset = 1;
        tick();
        reset = 0;
        rsp_ready = 1;
        @(negedge clock);
        chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            chk("no_stale_rsp", 64'(rsp_valid), 64'd0);
        end
        tick();
        set_req(0, 1'b0, 32'h8000_0000, 32'h0001_0000, 32'h4, 32'h0001_0000, 4'd11);
        req_valid = 2'b01;
        wait_grant(0, t0);
        tick();
        req_valid = 0;
        wait_rsp(t1);
        chk("post_rst_latency", 64'(t1 - t0), 64'd4);
        chk("post_rst_data", rsp_data, 64'h0000_0002_0000_0001);
        chk("post_rst_src_tag", 64'({rsp_src, rsp_tag}), 64'h0b);
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
